// File: rtl/demux_1x2_stream.sv
`default_nettype none
// ============================================================================
// Module : demux_1x2_stream
// Brief  : Registered 1:2 valid/ready stream demux with per-channel counters
// Rev    : 1.0  initial release
// ============================================================================
module demux_1x2_stream #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic [WIDTH-1:0] in_data_i,
    input  logic             in_sel_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    output logic [WIDTH-1:0] out0_data_o,
    output logic             out0_valid_o,
    input  logic             out0_ready_i,
    output logic [WIDTH-1:0] out1_data_o,
    output logic             out1_valid_o,
    input  logic             out1_ready_i,
    output logic [CNT_W-1:0] cnt0_o,
    output logic [CNT_W-1:0] cnt1_o
);

    localparam int c_NUM_CH = 2;

    logic [c_NUM_CH-1:0] w_out_ready;
    logic [c_NUM_CH-1:0] w_fill;
    logic [c_NUM_CH-1:0] w_drain;
    logic [c_NUM_CH-1:0] r_valid;
    logic [WIDTH-1:0]    r_data [c_NUM_CH];
    logic [CNT_W-1:0]    r_cnt  [c_NUM_CH];
    logic                w_slot_free;
    logic                w_accept;

    assign w_out_ready = {out1_ready_i, out0_ready_i};

    // Only the addressed channel gates the input, so a stalled channel never
    // blocks traffic for the other one; a draining slot may be refilled.
    assign w_slot_free = ~r_valid[in_sel_i] | w_out_ready[in_sel_i];
    assign in_ready_o  = ~reset_i & w_slot_free;
    assign w_accept    = in_valid_i & in_ready_o;
    assign w_drain     = r_valid & w_out_ready;
    assign w_fill      = w_accept ? (in_sel_i ? 2'b10 : 2'b01) : 2'b00;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            for (int n = 0; n < c_NUM_CH; n++) begin
                r_valid[n] <= 1'b0;
                r_data[n]  <= '0;
                r_cnt[n]   <= '0;
            end
        end else begin
            for (int n = 0; n < c_NUM_CH; n++) begin
                if (w_fill[n]) begin
                    r_valid[n] <= 1'b1;
                    r_data[n]  <= in_data_i;
                end else if (w_drain[n]) begin
                    r_valid[n] <= 1'b0;
                end
                if (w_drain[n]) begin
                    r_cnt[n] <= r_cnt[n] + CNT_W'(1);
                end
            end
        end
    end

    assign out0_valid_o = r_valid[0];
    assign out1_valid_o = r_valid[1];
    assign out0_data_o  = r_data[0];
    assign out1_data_o  = r_data[1];
    assign cnt0_o       = r_cnt[0];
    assign cnt1_o       = r_cnt[1];

endmodule
`default_nettype wire
